// File: rtl/iob_irq_ctrl.sv
// Interrupt sink/arbiter: per-line sync + edge/level capture, mask, fixed-priority
// claim/complete over the native slave bus, one registered irq to the CPU.
module iob_irq_lane (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic edge_mode,
    input  logic clr,
    input  logic claim,
    output logic pending
);
    logic s1, s2, prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            prev    <= 1'b0;
            pending <= 1'b0;
        end else begin
            s1   <= src;
            s2   <= s1;
            prev <= s2;
            // a fresh edge beats a simultaneous clear or claim
            if (edge_mode) pending <= (s2 & ~prev) | (pending & ~clr & ~claim);
            else           pending <= s2;
        end
    end
endmodule

module iob_irq_ctrl #(
    parameter int N_SRC  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    input  logic [N_SRC-1:0]  src,
    output logic              irq
);
    localparam logic [ADDR_W-1:0] A_PEND  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_EN    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_EDGE  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CLR   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_CLAIM = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CMPL  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(6);

    typedef enum logic {IDLE, IN_SERVICE} state_t;
    state_t state, state_nxt;

    logic [N_SRC-1:0]  pending, enable, edge_mode, clr_vec, claim_vec, eligible;
    logic [4:0]        active_id, winner;
    logic              acc, wr, rd, busy, claim_ok, complete_ok;
    logic [DATA_W-1:0] rd_val;
    logic              unused_ok;

    assign unused_ok = ^wdata;
    // one-cycle ack; a held valid is only taken again after ready drops
    assign acc      = valid & ~ready;
    assign wr       = acc & (|wstrb);
    assign rd       = acc & ~(|wstrb);
    assign busy     = (state == IN_SERVICE);
    assign eligible = pending & enable;
    assign clr_vec  = (wr && address == A_CLR) ? wdata[N_SRC-1:0] : '0;
    assign claim_vec = {{(N_SRC-1){1'b0}}, claim_ok} << winner;

    for (genvar i = 0; i < N_SRC; i++) begin : g_lane
        iob_irq_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .src      (src[i]),
            .edge_mode(edge_mode[i]),
            .clr      (clr_vec[i]),
            .claim    (claim_vec[i]),
            .pending  (pending[i])
        );
    end

    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (eligible[i]) winner = 5'(i);
    end

    always_comb begin
        state_nxt   = state;
        claim_ok    = 1'b0;
        complete_ok = 1'b0;
        case (state)
            IDLE: if (rd && address == A_CLAIM && (|eligible)) begin
                claim_ok  = 1'b1;
                state_nxt = IN_SERVICE;
            end
            IN_SERVICE: if (wr && address == A_CMPL && wdata[4:0] == active_id) begin
                complete_ok = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (address)
            A_PEND:  rd_val = DATA_W'(pending);
            A_EN:    rd_val = DATA_W'(enable);
            A_EDGE:  rd_val = DATA_W'(edge_mode);
            A_CLAIM: rd_val = claim_ok ? DATA_W'(winner) + DATA_W'(1) : '0;
            A_STAT:  rd_val = DATA_W'({busy, 3'b000, active_id});
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            active_id <= '0;
            enable    <= '0;
            edge_mode <= '0;
            ready     <= 1'b0;
            rdata     <= '0;
            irq       <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= acc;
            rdata <= rd ? rd_val : '0;
            irq   <= (|eligible) & ~busy;
            if (claim_ok) active_id <= winner;
            if (wr && address == A_EN)   enable    <= wdata[N_SRC-1:0];
            if (wr && address == A_EDGE) edge_mode <= wdata[N_SRC-1:0];
        end
    end
endmodule

// File: tb/tb_iob_irq_ctrl.sv
// Directed bench for iob_irq_ctrl: reset, edge/level capture, priority, claim/complete, clear race.
module tb_iob_irq_ctrl;
    logic        clk = 1'b0, rst = 1'b0, valid = 1'b0;
    logic [2:0]  address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [7:0]  src = '0;
    logic        irq;
    logic [31:0] r;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    iob_irq_ctrl #(.N_SRC(8), .ADDR_W(3), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .src(src), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] q);
        @(negedge clk);
        valid = 1'b1; address = a; wdata = d; wstrb = s;
        @(posedge clk); #1;
        q = rdata;
        chk("bus_ready", {31'b0, ready}, 32'd1);
        valid = 1'b0; wstrb = '0;
        @(posedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(a, d, 4'hF, dummy);
    endtask

    initial begin
        // reset held with all lines high
        src = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk); rst = 1'b1;
        repeat (4) @(posedge clk);
        bus(3'd0, 0, 4'h0, r); chk("lvl_pending_ff", r, 32'hFF);
        #1 chk("irq_disabled", {31'b0, irq}, 32'd0);

        // held valid: ready 1, then 0, then a new access
        @(negedge clk); valid = 1'b1; address = 3'd1; wstrb = 4'h0;
        @(posedge clk); #1 chk("hold_rdy0", {31'b0, ready}, 32'd1);
        @(posedge clk); #1 chk("hold_rdy1", {31'b0, ready}, 32'd0);
        @(posedge clk); #1 chk("hold_rdy2", {31'b0, ready}, 32'd1);
        valid = 1'b0;
        @(posedge clk);
        wr(3'd7, 32'hFFFF_FFFF);
        bus(3'd7, 0, 4'h0, r); chk("unmapped", r, 32'd0);

        // edge mode, single pulse on src[3]
        wr(3'd2, 32'hFF);
        bus(3'd0, 0, 4'h0, r); chk("edge_keeps_pend", r, 32'hFF);
        wr(3'd3, 32'hFF);
        @(negedge clk); src = 8'h00;
        repeat (4) @(posedge clk);
        wr(3'd1, 32'hFFFF_FF08);
        bus(3'd1, 0, 4'h0, r); chk("enable_rb", r, 32'h08);
        bus(3'd0, 0, 4'h0, r); chk("pend_clear", r, 32'h00);
        @(negedge clk); src = 8'h08;
        @(negedge clk); src = 8'h00;
        @(posedge clk); #1 chk("irq_k1", {31'b0, irq}, 32'd0);
        @(posedge clk); #1 chk("irq_k2", {31'b0, irq}, 32'd0);
        @(posedge clk); #1 chk("irq_k3", {31'b0, irq}, 32'd1);
        bus(3'd0, 0, 4'h0, r); chk("pend_08", r, 32'h08);
        bus(3'd4, 0, 4'h0, r); chk("claim_4", r, 32'd4);
        #1 chk("irq_after_claim", {31'b0, irq}, 32'd0);
        bus(3'd0, 0, 4'h0, r); chk("pend_claimed", r, 32'h00);
        wr(3'd5, 32'd3);

        // priority: src[5] and src[2] together
        wr(3'd1, 32'hFF);
        @(negedge clk); src = 8'h24;
        @(negedge clk); src = 8'h00;
        repeat (4) @(posedge clk);
        #1 chk("irq_prio", {31'b0, irq}, 32'd1);
        bus(3'd4, 0, 4'h0, r); chk("claim_3", r, 32'd3);
        bus(3'd4, 0, 4'h0, r); chk("claim_busy", r, 32'd0);
        #1 chk("irq_busy", {31'b0, irq}, 32'd0);
        bus(3'd6, 0, 4'h0, r); chk("status_busy", r, 32'h102);
        wr(3'd5, 32'd7);
        bus(3'd6, 0, 4'h0, r); chk("status_badcmpl", r, 32'h102);
        wr(3'd5, 32'd2);
        #1 chk("irq_reraise", {31'b0, irq}, 32'd1);
        bus(3'd6, 0, 4'h0, r); chk("status_idle", r, 32'h002);
        bus(3'd4, 0, 4'h0, r); chk("claim_6", r, 32'd6);
        wr(3'd5, 32'd5);

        // level mode on src[0]
        wr(3'd2, 32'h00);
        wr(3'd1, 32'h01);
        @(negedge clk); src = 8'h01;
        repeat (4) @(posedge clk);
        #1 chk("irq_level", {31'b0, irq}, 32'd1);
        bus(3'd4, 0, 4'h0, r); chk("claim_1", r, 32'd1);
        wr(3'd5, 32'd0);
        #1 chk("irq_level_again", {31'b0, irq}, 32'd1);
        wr(3'd3, 32'h01);
        bus(3'd0, 0, 4'h0, r); chk("lvl_clr_noeff", r, 32'h01);
        @(negedge clk); src = 8'h00;
        repeat (2) @(posedge clk);
        bus(3'd0, 0, 4'h0, r); chk("lvl_drop_early", r, 32'h01);
        bus(3'd0, 0, 4'h0, r); chk("lvl_drop", r, 32'h00);

        // clear written on the same edge that a new src[4] edge sets pending
        wr(3'd1, 32'h00);
        wr(3'd2, 32'hFF);
        @(negedge clk); src = 8'h10;
        repeat (2) @(posedge clk);
        wr(3'd3, 32'h10);
        bus(3'd0, 0, 4'h0, r); chk("clr_race", r, 32'h10);
        wr(3'd3, 32'h10);
        bus(3'd0, 0, 4'h0, r); chk("clr_after", r, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
